// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared FSM state encoding, op select codes and default width
// for the bit-serial add/subtract controller.
package serial_addsub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/FullADD.sv
// FullADD: 1-bit full adder cell.
module FullADD (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial A+B / A-B, LSB first, one bit per clock.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output OVF.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             C_O
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             carry, co_q, load, last, sum, cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q;
    assign OVF = ovf_q;
`endif

    assign BUSY = state == RUN;
    assign DONE = state == serial_addsub_pkg::DONE;
    assign S    = s_q;
    assign C_O  = co_q;
    assign last = cnt == CW'(WIDTH - 1);

    FullADD u_fa (
        .a (a_q[cnt]),
        .b (b_q[cnt]),
        .ci(carry),
        .s (sum),
        .co(cout)
    );

    always_comb begin
        state_n = (state == RUN) ? (last ? serial_addsub_pkg::DONE : RUN)
                                 : (START ? RUN : IDLE);
        load    = (state != RUN) && START;
    end

    // Subtraction is A + ~B + 1: B is stored inverted and the carry seeded with SUB.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            co_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (load) begin
                a_q   <= A;
                b_q   <= SUB ? ~B : B;
                cnt   <= '0;
                carry <= SUB;
            end else if (state == RUN) begin
                s_q[cnt] <= sum;
                carry    <= cout;
                cnt      <= last ? cnt : cnt + 1'b1;
                if (last) begin
                    co_q  <= cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_q <= carry ^ cout;
`endif
                end
            end
        end
    end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-003 Port: RST_N  in  1  reset, synchronous, active-low.
REQ-004 Port: START  in  1  request to begin one operation; sampled only in IDLE or DONE.
REQ-005 Port: SUB  in  1  operation select captured with START: 0 = A+B, 1 = A-B.
REQ-006 Port: A  in  WIDTH  operand A, captured with START.
REQ-007 Port: B  in  WIDTH  operand B, captured with START.
REQ-008 Port: BUSY  out  1  high while bits are being processed.
REQ-009 Port: DONE  out  1  one-cycle pulse marking a valid result.
REQ-010 Port: S  out  WIDTH  result register.
REQ-011 Port: C_O  out  1  final carry out; for SUB, 1 = no borrow.
REQ-012 Port: OVF  out  1  signed overflow; present only with SERIAL_ADDSUB_OVF_EN.

Function
REQ-013 The block SHALL compute the result bit-serially, LSB first, using one 1-bit full-adder cell and a carry flip-flop, one bit per clock.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE -> RUN on START=1; operands, SUB latched; bit counter = 0; carry FF = SUB; B operand inverted when SUB=1.
REQ-016 RUN: each cycle add bit[cnt] of A, (B or ~B), carry FF; write sum into S[cnt]; update carry FF; cnt++.
REQ-017 RUN -> DONE after bit WIDTH-1 is processed (exactly WIDTH RUN cycles); DONE state lasts one cycle.
REQ-018 Latency: START sampled at edge k -> BUSY high during the WIDTH cycles after edge k, DONE high for the single cycle after edge k+WIDTH.
REQ-019 DONE -> RUN if START=1 in DONE (back-to-back, no idle gap); else DONE -> IDLE.
REQ-020 START while in RUN SHALL be ignored; latched operands SHALL not change.
REQ-021 S, C_O (and OVF) SHALL hold their final value from DONE until the next accepted START; intermediate S bits change only during RUN.
REQ-022 C_O SHALL equal carry out of bit WIDTH-1; arithmetic is modulo 2^WIDTH.
REQ-023 Bit counter SHALL be $clog2(WIDTH) bits and SHALL not wrap within an operation.

Reset
REQ-024 RST_N=0 at a clock edge SHALL force IDLE, S=0, C_O=0, OVF=0, BUSY=0, DONE=0, counter=0, carry FF=0, regardless of state.
REQ-025 Reset during RUN SHALL abort the operation with no DONE pulse; START on the first edge after RST_N returns high SHALL be accepted.

Configuration
REQ-026 Macro SERIAL_ADDSUB_OVF_EN defined: OVF port exists, equals carry-into-MSB XOR carry-out-of-MSB, updated on the final RUN cycle.
REQ-027 Macro undefined: OVF port, its register and the carry-into-MSB capture SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package serial_addsub_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE), the SUB op encoding constants and the WIDTH default.
REQ-029 The 1-bit adder SHALL be a single instance of the team's existing FullADD cell; no other sub-module.

Verification
REQ-030 WIDTH=8, START, SUB=0, A=0x3C, B=0x05 -> BUSY 8 cycles, DONE pulse 9th cycle, S=0x41, C_O=0, OVF=0.
REQ-031 SUB=0, A=0xFF, B=0x01 -> S=0x00, C_O=1, OVF=0; A=0x7F, B=0x01 -> S=0x80, C_O=0, OVF=1.
REQ-032 SUB=1, A=0x05, B=0x07 -> S=0xFE, C_O=0, OVF=0; A=0x80, B=0x01 -> S=0x7F, C_O=1, OVF=1.
REQ-033 START held high through RUN with changing A/B -> result reflects first-captured operands; START high in DONE -> next RUN begins next cycle, DONE pulses every 9 cycles.
REQ-034 RST_N low at 4th RUN cycle -> next edge all outputs 0, state IDLE, no DONE pulse; new START after release completes normally.
REQ-035 Build without SERIAL_ADDSUB_OVF_EN -> compiles with no OVF port; REQ-030..REQ-032 S/C_O values unchanged.
